// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control and status signals between the sequencer and its host
interface cpu_sequencer_if;
  logic        run;
  logic        step;
  logic        halt_req;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic        PCincr;
  logic        Aload;
  logic        Bload;
  logic [7:0]  jump_addr;
  logic [3:0]  alu_nzvc;
  logic [7:0]  PC;
  logic [3:0]  NZVC;
  logic        exec_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic        self_jmp;
  logic [15:0] cycle_count;

  modport master (
    output run, step, halt_req, bp_en, bp_addr, PCincr, Aload, Bload, jump_addr, alu_nzvc,
    input  PC, NZVC, exec_en, state, bp_hit, self_jmp, cycle_count
  );

  modport slave (
    input  run, step, halt_req, bp_en, bp_addr, PCincr, Aload, Bload, jump_addr, alu_nzvc,
    output PC, NZVC, exec_en, state, bp_hit, self_jmp, cycle_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - run/step/halt sequencer with PC, flag register, breakpoint and cycle counter
module cpu_sequencer (
  input logic            clk,
  input logic            reset,
  cpu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t      state_q;
  logic        step_q;
  logic        first_q;
  logic [7:0]  pc_q;
  logic [3:0]  nzvc_q;
  logic        bp_hit_q;
  logic        self_jmp_q;
  logic [15:0] count_q;

  logic step_edge;
  logic bp_take;
  logic exec;
  logic self_hit;

  // first_q marks the first RUN cycle after HALT so a breakpoint at the resume PC is stepped over
  assign step_edge = bus.step & ~step_q;
  assign bp_take   = (state_q == RUN) & ~first_q & bus.bp_en & (pc_q == bus.bp_addr);
  assign exec      = (state_q == STEP) | ((state_q == RUN) & ~bp_take);
  assign self_hit  = (state_q == RUN) & exec & ~bus.PCincr & (bus.jump_addr == pc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HALT;
      step_q     <= 1'b0;
      first_q    <= 1'b1;
      pc_q       <= 8'h00;
      nzvc_q     <= 4'h0;
      bp_hit_q   <= 1'b0;
      self_jmp_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      step_q  <= bus.step;
      first_q <= (state_q != RUN);

      if (exec) begin
        pc_q <= bus.PCincr ? pc_q + 8'h01 : bus.jump_addr;
        if (bus.Aload || bus.Bload)
          nzvc_q <= bus.alu_nzvc;
        if (count_q != 16'hFFFF)
          count_q <= count_q + 16'h0001;
      end

      case (state_q)
        HALT: begin
          if (bus.run) begin
            state_q    <= RUN;
            bp_hit_q   <= 1'b0;
            self_jmp_q <= 1'b0;
          end else if (step_edge) begin
            state_q    <= STEP;
            bp_hit_q   <= 1'b0;
            self_jmp_q <= 1'b0;
          end
        end
        RUN: begin
          // Breakpoint outranks halt_req and the self-jump check since nothing executes
          if (bp_take) begin
            bp_hit_q <= 1'b1;
            state_q  <= HALT;
          end else if (self_hit) begin
            self_jmp_q <= 1'b1;
            state_q    <= HALT;
          end else if (bus.halt_req || !bus.run) begin
            state_q <= HALT;
          end
        end
        STEP:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  assign bus.PC          = pc_q;
  assign bus.NZVC        = nzvc_q;
  assign bus.exec_en     = exec;
  assign bus.state       = state_q;
  assign bus.bp_hit      = bp_hit_q;
  assign bus.self_jmp    = self_jmp_q;
  assign bus.cycle_count = count_q;
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line as name  direction  width  meaning:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 requests free-running execution.
- step  in  1  single-step request; only its rising edge (registered internally) counts.
- halt_req  in  1  level; stops RUN.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  8  breakpoint PC value.
- PCincr  in  1  from control ROM; 1 = PC+1, 0 = load jump_addr.
- Aload  in  1  from control ROM.
- Bload  in  1  from control ROM.
- jump_addr  in  8  jump target from the current instruction.
- alu_nzvc  in  4  ALU flag outputs {N,Z,V,C}.
- PC  out  8  program counter; drives control-ROM address bits 7:0.
- NZVC  out  4  flag register; drives control-ROM address bits 11:8.
- exec_en  out  1  1 = current cycle executes; qualifies Aload/Bload/RAMwrite downstream.
- state  out  2  00 HALT, 01 RUN, 10 STEP.
- bp_hit  out  1  sticky breakpoint-taken flag.
- self_jmp  out  1  sticky jump-to-self halt flag.
- cycle_count  out  16  executed-cycle counter.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 The FSM SHALL have three states: HALT, RUN and STEP; encoding 11 SHALL never occur and SHALL recover to HALT.
REQ-004 exec_en SHALL be 1 in STEP, 1 in RUN unless a breakpoint is taken that cycle (REQ-010), and 0 in HALT.
REQ-005 On an executed cycle, PC SHALL become PC+1 mod 256 when PCincr=1 and jump_addr when PCincr=0; 0xFF+1 wraps to 0x00.
REQ-006 On an executed cycle with Aload=1 or Bload=1, NZVC SHALL load alu_nzvc; otherwise NZVC SHALL hold.
REQ-007 PC, NZVC and cycle_count SHALL hold on every non-executed cycle.
REQ-008 HALT transitions: run=1 -> RUN; else step edge -> STEP; run and step edge together -> RUN, and the step edge is discarded.
REQ-009 STEP SHALL last exactly one cycle and then return to HALT, whatever the state of run.
REQ-010 In RUN, when bp_en=1, PC==bp_addr and the cycle is not the first RUN cycle after leaving HALT, exec_en SHALL be 0, bp_hit SHALL set and the next state SHALL be HALT.
REQ-011 Breakpoints SHALL be ignored in STEP and on the first RUN cycle after HALT, so execution resumes past a breakpoint.
REQ-012 In RUN, halt_req=1 or run=0 SHALL make the next state HALT; the current cycle still executes.
REQ-013 A breakpoint taken in the same cycle as halt_req SHALL take priority: no execution, bp_hit set.
REQ-014 An executed RUN cycle with PCincr=0 and jump_addr==PC SHALL set self_jmp and make the next state HALT; PC stays unchanged.
REQ-015 bp_hit and self_jmp SHALL clear on entry to RUN or STEP.
REQ-016 Step edges that arrive while in RUN or STEP SHALL be ignored and SHALL NOT be queued.
REQ-017 cycle_count SHALL increment by 1 on each executed cycle and saturate at 0xFFFF.

Reset
REQ-018 While reset=0, asynchronously: state=HALT, PC=0x00, NZVC=0x0, exec_en=0, bp_hit=0, self_jmp=0, cycle_count=0x0000, and the step edge register cleared.
REQ-019 Reset asserted mid-RUN SHALL abort immediately; after release the block SHALL stay in HALT until run or a step edge.

Verification
REQ-020 Reset, run=1, PCincr=1 for 300 cycles -> PC sequence 00,01,...,FF,00,...; cycle_count=300.
REQ-021 HALT at PC=0x10, step edge with PCincr=0, jump_addr=0x40 -> exactly one cycle with exec_en=1, PC=0x40, then state=HALT.
REQ-022 bp_en=1, bp_addr=0x05, run=1 from PC=0 -> PC stops at 0x05 with exec_en=0 that cycle and bp_hit=1; holding run=1 resumes and executes 0x05, and bp_hit clears.
REQ-023 RUN at PC=0x20 with PCincr=0, jump_addr=0x20 -> self_jmp=1, state=HALT, PC=0x20.
REQ-024 Aload=1, alu_nzvc=0xA on an executed cycle -> NZVC=0xA; the same inputs during HALT -> NZVC unchanged.
REQ-025 reset pulsed low mid-RUN at PC=0x33 -> all outputs at REQ-018 values without waiting for a clock edge; state stays HALT after release with run=0.
